// File: rtl/serial_add_sub_unit_if.sv
// Handshake bundle for serial_add_sub_unit: operand side (in_valid/in_ready,
// mode, a, b) and result side (out_valid/out_ready, result, carry, flags).
interface serial_add_sub_unit_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic             mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             overflow;
   logic             zero;
   logic             negative;

   modport master (
      output in_valid, mode, a, b, out_ready,
      input  in_ready, out_valid, result, carry, overflow, zero, negative
   );

   modport slave (
      input  in_valid, mode, a, b, out_ready,
      output in_ready, out_valid, result, carry, overflow, zero, negative
   );
endinterface

// File: rtl/serial_add_sub_unit.sv
// Digit-serial add/sub: DIGIT bits per clock, WIDTH/DIGIT clocks per op.
// Ports: clk, rst_n (async low), io (slave: operands in, result+flags out).
module serial_add_sub_unit #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_add_sub_unit_if.slave  io
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             mode_q, mode_d;
   logic             cy_q, cy_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;

   logic [DIGIT-1:0] a_dig;
   logic [DIGIT-1:0] b_dig;
   logic [DIGIT-1:0] s_dig;
   logic             c_out;
   logic             c_msb;
   int               idx;

   always_comb begin
      idx   = int'(cnt_q) * DIGIT;
      a_dig = a_q[idx +: DIGIT];
      b_dig = b_q[idx +: DIGIT];
      {c_out, s_dig} = {1'b0, a_dig} + {1'b0, b_dig}
                     + {{DIGIT{1'b0}}, cy_q};
      // carry into the digit's top bit recovered from a^b^sum
      c_msb = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ s_dig[DIGIT-1];

      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      mode_d  = mode_q;
      cy_d    = cy_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      neg_d   = neg_q;

      unique case (state_q)
         IDLE: begin
            if (io.in_valid) begin
               a_d     = io.a;
               b_d     = io.mode ? ~io.b : io.b;
               mode_d  = io.mode;
               cy_d    = io.mode;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d[idx +: DIGIT] = s_dig;
            cy_d  = c_out;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
               carry_d = c_out ^ mode_q;
               ovf_d   = c_msb ^ c_out;
               zero_d  = (res_d == '0);
               neg_d   = res_d[WIDTH-1];
               state_d = DONE;
            end
         end
         DONE: begin
            if (io.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         mode_q  <= 1'b0;
         cy_q    <= 1'b0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         mode_q  <= mode_d;
         cy_q    <= cy_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
      end
   end

   assign io.in_ready  = (state_q == IDLE);
   assign io.out_valid = (state_q == DONE);
   assign io.result    = res_q;
   assign io.carry     = carry_q;
   assign io.overflow  = ovf_q;
   assign io.zero      = zero_q;
   assign io.negative  = neg_q;

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Bench for serial_add_sub_unit: directed 8/4 vectors, backpressure,
// async reset mid-op, and randomized sweeps over four WIDTH/DIGIT configs.
module tb_serial_add_sub_unit;

   logic clk;
   logic rst_n;
   logic rst_s_n;
   int   n_tot;
   int   n_bad;
   bit   sw_done [4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   serial_add_sub_unit_if #(.WIDTH(8)) mif ();

   serial_add_sub_unit #(
      .WIDTH(8),
      .DIGIT(4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (mif.slave)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] obs();
      return {mif.result, mif.carry, mif.overflow, mif.zero, mif.negative};
   endfunction

   // called #1 after an edge while the unit is idle
   task automatic run_op(input string tag, input logic m,
                         input logic [7:0] ea, input logic [7:0] eb,
                         input logic [11:0] exp);
      int lat;
      mif.mode     = m;
      mif.a        = ea;
      mif.b        = eb;
      mif.in_valid = 1'b1;
      @(posedge clk);
      #1;
      mif.in_valid = 1'b0;
      chk({tag, "_rdy_run"}, mif.in_ready, 0);
      lat = 0;
      while (!mif.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_lat"}, lat, 2);
      chk({tag, "_rdy_done"}, mif.in_ready, 0);
      chk(tag, obs(), exp);
   endtask

   task automatic pop();
      mif.out_ready = 1'b1;
      @(posedge clk);
      #1;
      mif.out_ready = 1'b0;
      chk("pop_vld", mif.out_valid, 0);
      chk("pop_rdy", mif.in_ready, 1);
   endtask

   for (genvar g = 0; g < 4; g++) begin : g_sw
      localparam int W = (g == 3) ? 16 : 8;
      localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 4;

      serial_add_sub_unit_if #(.WIDTH(W)) sif ();

      serial_add_sub_unit #(
         .WIDTH(W),
         .DIGIT(D)
      ) u_dut (
         .clk   (clk),
         .rst_n (rst_s_n),
         .io    (sif.slave)
      );

      initial begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic         rm;
         logic [W:0]   full;
         logic [W-1:0] er;
         logic         ec;
         logic         eo;
         int           lat;
         sif.in_valid  = 1'b0;
         sif.out_ready = 1'b0;
         sif.mode      = 1'b0;
         sif.a         = '0;
         sif.b         = '0;
         wait (rst_s_n);
         @(posedge clk);
         #1;
         for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rm = 1'($urandom);
            sif.a        = ra;
            sif.b        = rb;
            sif.mode     = rm;
            sif.in_valid = 1'b1;
            @(posedge clk);
            #1;
            sif.in_valid = 1'b0;
            lat = 0;
            while (!sif.out_valid && lat < 100) begin
               @(posedge clk);
               #1;
               lat++;
            end
            chk($sformatf("sw%0d_lat", g), lat, W / D);
            if (!rm) begin
               full = {1'b0, ra} + {1'b0, rb};
               er   = full[W-1:0];
               ec   = full[W];
               eo   = (ra[W-1] == rb[W-1]) && (er[W-1] != ra[W-1]);
            end else begin
               er = ra - rb;
               ec = (ra < rb);
               eo = (ra[W-1] != rb[W-1]) && (er[W-1] != ra[W-1]);
            end
            chk($sformatf("sw%0d_res a=%0h b=%0h m=%0d", g, ra, rb, rm),
                {sif.result, sif.carry, sif.overflow, sif.zero,
                 sif.negative},
                {er, ec, eo, (er == '0), er[W-1]});
            sif.out_ready = 1'b1;
            @(posedge clk);
            #1;
            sif.out_ready = 1'b0;
         end
         sw_done[g] = 1'b1;
      end
   end

   initial begin
      int guard;
      n_tot         = 0;
      n_bad         = 0;
      rst_n         = 1'b0;
      rst_s_n       = 1'b0;
      mif.in_valid  = 1'b0;
      mif.out_ready = 1'b0;
      mif.mode      = 1'b0;
      mif.a         = '0;
      mif.b         = '0;
      #12;
      chk("reset", {mif.in_ready, mif.out_valid, obs()}, 14'h2000);
      rst_n   = 1'b1;
      rst_s_n = 1'b1;
      @(posedge clk);
      #1;

      run_op("add_3c_05", 1'b0, 8'h3C, 8'h05, 12'h410);
      pop();
      run_op("sub_05_03", 1'b1, 8'h05, 8'h03, 12'h020);
      pop();
      run_op("sub_03_05", 1'b1, 8'h03, 8'h05, 12'hFE9);
      pop();
      run_op("sub_5a_5a", 1'b1, 8'h5A, 8'h5A, 12'h002);
      pop();
      run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 12'h805);
      pop();
      run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 12'h7F4);
      pop();
      run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 12'h00A);
      pop();
      run_op("sub_77_00", 1'b1, 8'h77, 8'h00, 12'h770);
      pop();

      run_op("bp", 1'b0, 8'h12, 8'h34, 12'h460);
      mif.mode     = 1'b1;
      mif.a        = 8'h20;
      mif.b        = 8'h30;
      mif.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_vld", mif.out_valid, 1);
         chk("bp_rdy", mif.in_ready, 0);
         chk("bp_hold", obs(), 12'h460);
      end
      mif.out_ready = 1'b1;
      @(posedge clk);
      #1;
      mif.out_ready = 1'b0;
      chk("bp_drop", mif.out_valid, 0);
      chk("bp_rdy_idle", mif.in_ready, 1);
      chk("bp_keep", obs(), 12'h460);
      run_op("bp_new", 1'b1, 8'h20, 8'h30, 12'hF09);
      pop();

      mif.mode     = 1'b0;
      mif.a        = 8'h12;
      mif.b        = 8'h34;
      mif.in_valid = 1'b1;
      @(posedge clk);
      #1;
      mif.in_valid = 1'b0;
      chk("mr_run", mif.in_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_rst", {mif.in_ready, mif.out_valid, obs()}, 14'h2000);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("mr_idle", {mif.in_ready, mif.out_valid}, 2'b10);
      run_op("mr_sub", 1'b1, 8'h10, 8'h20, 12'hF09);
      pop();

      guard = 0;
      while (!(sw_done[0] && sw_done[1] && sw_done[2] && sw_done[3])
             && guard < 60000) begin
         @(posedge clk);
         guard++;
      end
      chk("sw_timeout",
          {sw_done[0], sw_done[1], sw_done[2], sw_done[3]}, 4'hF);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_add_sub_unit.md
Name: serial_add_sub_unit

Overview:
- Parametrised, digit-serial two's-complement adder/subtractor with valid/ready handshakes on input and output.
- Processes DIGIT bits per clock and returns a WIDTH-bit result plus carry/borrow, overflow, zero and negative flags.
- Subtraction is A + ~B + 1, and borrow is the inverted carry-out.
- Sits in the arithmetic datapath as the sequential successor to the fixed 4-bit combinational subtract path, trading latency for adder area.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT, and at least 2.
- DIGIT, 4, bits processed per clock; N = WIDTH/DIGIT cycles per operation; allowed range is 1 to WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand and mode presented.
- in_ready  output  1  unit can accept an operation.
- mode  input  1  0 = A+B, 1 = A-B.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- carry  output  1  add: carry-out; sub: borrow (1 when A < B unsigned).
- overflow  output  1  signed overflow.
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH-1].

Behaviour:
- Reset and clocking (already decided): one clock, clk; rst_n asynchronous, active-low.
- Reset state: state=IDLE, in_ready=1, out_valid=0; result, carry, overflow, zero and negative all 0; internal counter and operand registers 0.
- Reset mid-operation: the operation in progress is abandoned and the state above is reached immediately. No partial result ever appears.
- States: IDLE, RUN, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE. Both are decoded from registered state.
- IDLE: when in_valid && in_ready at a rising edge:
  - capture a, the b operand (inverted when mode=1) and mode;
  - set the running carry to mode;
  - set the digit counter to 0; go to RUN.
  - Otherwise stay in IDLE.
- RUN: each edge adds digit k (bits k*DIGIT to k*DIGIT+DIGIT-1) of A and B' plus the running carry.
  - Store the DIGIT sum bits in result, LSB digit first.
  - Update the running carry and increment k.
  - On the edge with k == N-1, also latch the flags and go to DONE.
  - Input changes during RUN have no effect.
- Latency: out_valid rises exactly N edges after the accepting edge. For WIDTH=8, DIGIT=4 that is 2 edges. One operation is in flight at a time.
- DONE: result and flags are held stable while out_valid && !out_ready. in_valid is ignored (in_ready=0).
  - When out_ready=1 at an edge: go to IDLE; outputs keep their values but out_valid drops.
  - in_ready becomes 1 the cycle after the output handshake. There is no same-cycle re-accept.
- Flags, latched at the final digit:
  - carry = cout XOR mode;
  - overflow = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1);
  - zero = (final result == 0);
  - negative = final result[WIDTH-1].
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - DIGIT=WIDTH gives single-cycle RUN (N=1).
  - DIGIT=1 gives bit-serial operation (N=WIDTH).
- Boundary cases:
  - Subtracting 0 gives borrow=0.
  - A-A gives zero=1, borrow=0.
  - Simultaneous in_valid while in DONE is ignored, not queued.

Test Plan:
- WIDTH=8, DIGIT=4, mode=0, a=0x3C, b=0x05 -> result=0x41, carry=0, overflow=0, zero=0, negative=0; out_valid exactly 2 edges after accept; in_ready=0 during RUN/DONE.
- mode=1: a=0x05, b=0x03 -> 0x02, borrow=0. Then a=0x03, b=0x05 -> 0xFE, borrow=1, negative=1, overflow=0. Then a=0x5A, b=0x5A -> 0x00, zero=1, borrow=0.
- Overflow:
  - add 0x7F+0x01 -> 0x80, overflow=1, carry=0, negative=1;
  - sub 0x80-0x01 -> 0x7F, overflow=1, borrow=0;
  - add 0xFF+0x01 -> 0x00, carry=1, zero=1, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while driving in_valid=1 with new operands -> result and flags stable, out_valid stays 1, no new accept. out_ready=1 -> out_valid=0 next cycle, in_ready=1, and the new op is accepted with the correct result.
- Reset mid-operation: assert rst_n=0 asynchronously (off clock edge) in the first RUN cycle -> all outputs 0 and in_ready=1 immediately. A subsequent 0x10-0x20 -> 0xF0, borrow=1.
- Parameter sweep: WIDTH=8 with DIGIT in {1, 2, 8}, and WIDTH=16 with DIGIT=4, over random a/b/mode (≥1000 ops each) against a reference model -> all results and flags match; latency = WIDTH/DIGIT edges.
